// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write bus between a boot host and program_loader.
// master is the host/memory side, slave is the loader that consumes bytes and issues writes.
interface program_loader_if #(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 8
);
  logic [7:0]           byte_in;
  logic                 byte_valid;
  logic                 byte_ready;
  logic                 mem_we;
  logic [ADD_WIDTH-1:0] mem_add;
  logic [WIDTH-1:0]     mem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_add, mem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_add, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: assembles little-endian serial bytes into words and writes them to program
// memory, holding the core in reset until a halt word or the last address has been written.
module program_loader #(
  parameter int DEPTH     = 256,
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  program_loader_if.slave      bus,
  output logic                 busy,
  output logic                 done,
  output logic                 core_hold,
  output logic [ADD_WIDTH:0]   word_count
);

  localparam int BYTES = WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [WIDTH-1:0]     HALT_WORD = WIDTH'(32'h0000_007F);
  localparam logic [ADD_WIDTH-1:0] LAST_ADD  = ADD_WIDTH'(DEPTH - 1);
  localparam logic [BCW-1:0]       LAST_BYTE = BCW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [BCW-1:0]   byte_cnt;
  logic [WIDTH-1:0] asm_word;
  logic [WIDTH-1:0] next_word;
  logic             accept;
  logic             last_byte;
  logic             finish;

  // Handshake is decided from the state directly so byte_ready never feeds back into itself.
  assign accept    = (state == LOAD) && bus.byte_valid;
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign finish    = (bus.mem_wdata == HALT_WORD) || (bus.mem_add == LAST_ADD);

  always_comb begin
    next_word = asm_word;
    next_word[int'(byte_cnt) * 8 +: 8] = bus.byte_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state     = state;
    bus.byte_ready = 1'b0;
    bus.mem_we     = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    core_hold      = 1'b1;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
      end
      LOAD: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (accept && last_byte) next_state = WRITE;
      end
      WRITE: begin
        bus.mem_we = 1'b1;
        busy       = 1'b1;
        next_state = finish ? DONE : LOAD;
      end
      DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
        if (start) next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  // mem_wdata only changes when a full word is assembled, so the memory bus stays quiet between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt      <= '0;
      asm_word      <= '0;
      bus.mem_add   <= '0;
      bus.mem_wdata <= '0;
      word_count    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            byte_cnt    <= '0;
            bus.mem_add <= '0;
            word_count  <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            asm_word <= next_word;
            if (last_byte) begin
              bus.mem_wdata <= next_word;
              byte_cnt      <= '0;
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
        end
        WRITE: begin
          word_count <= word_count + (ADD_WIDTH + 1)'(1);
          if (!finish) bus.mem_add <= bus.mem_add + ADD_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: a program-level model predicts each memory
// write, and a negedge monitor pops and compares every mem_we the loader produces.
module tb_program_loader;

  localparam int DEPTH = 256;
  localparam int WIDTH = 32;
  localparam int ADD_WIDTH = 8;
  localparam logic [31:0] HALT = 32'h0000_007F;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          index;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic core_hold;
  logic [ADD_WIDTH:0] word_count;

  program_loader_if #(.WIDTH(WIDTH), .ADD_WIDTH(ADD_WIDTH)) bus ();

  program_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADD_WIDTH(ADD_WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .core_hold  (core_hold),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  toggle_mode = 1'b0;
  bit  phase = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (!rst && bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.mem_add, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_output("write_addr", 64'(bus.mem_add), 64'(e.addr));
        check_output("write_data", 64'(bus.mem_wdata), 64'(e.data));
        check_output("write_index", 64'(word_count), 64'(e.index));
      end
    end
  end

  // Number of words the loader should write: stops after a halt word or the last address.
  function automatic int model_len(input logic [31:0] w[$]);
    int n = 0;
    for (int i = 0; i < w.size(); i++) begin
      n = i + 1;
      if (w[i] == HALT || i == DEPTH - 1) break;
    end
    return n;
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.byte_in = 8'($urandom);
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    bus.byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    phase = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (toggle_mode) phase = ~phase;
      if (toggle_mode ? phase : ($urandom_range(0, 2) == 0)) begin
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'($urandom);
      end else begin
        bus.byte_valid = 1'b1;
        bus.byte_in = b;
        if (bus.byte_ready === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL byte_handshake_timeout: got no byte_ready, expected acceptance of 0x%0h", b);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] words[$], input int base, input int n,
                                input bit pulse_mid);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        if (pulse_mid && i == 1 && k == 2) begin
          @(negedge clk);
          bus.byte_valid = 1'b0;
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
        if (k == 3) exp_q.push_back('{addr: 8'(base + i), data: w, index: base + i});
        send_byte(w[8*k +: 8]);
      end
      @(negedge clk);
      bus.byte_valid = 1'b0;
      check_output("we_latency", 64'(bus.mem_we), 64'd1);
    end
  endtask

  task automatic wait_done(input int n);
    bit seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("done_reached", 64'(seen), 64'd1);
    check_output("done_core_hold", 64'(core_hold), 64'd0);
    check_output("done_busy", 64'(busy), 64'd0);
    check_output("done_word_count", 64'(word_count), 64'(n));
    check_output("done_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
    check_output({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    check_output({tag, "_mem_add"}, 64'(bus.mem_add), 64'd0);
    check_output({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_done"}, 64'(done), 64'd0);
    check_output({tag, "_core_hold"}, 64'(core_hold), 64'd1);
    check_output({tag, "_word_count"}, 64'(word_count), 64'd0);
  endtask

  task automatic gen_program(input int len, output logic [31:0] w[$]);
    w = {};
    for (int i = 0; i < len - 1; i++) begin
      logic [31:0] r;
      r = $urandom;
      if (r == HALT) r = 32'h0000_0013;
      w.push_back(r);
    end
    w.push_back(HALT);
    if (len > 2 && $urandom_range(0, 3) == 0) w[$urandom_range(0, len - 2)] = HALT;
  endtask

  initial begin
    logic [31:0] prog[$];
    int n;

    rst = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle_cycles(2);
    check_output("idle_core_hold", 64'(core_hold), 64'd1);

    $display("[TB] directed three-word load with alternating byte_valid");
    toggle_mode = 1'b1;
    start_load();
    prog = {32'h0080_0093};
    apply_stimulus(prog, 0, 1, 1'b0);
    idle_cycles(2);
    check_output("one_word_count", 64'(word_count), 64'd1);
    check_output("one_word_ready", 64'(bus.byte_ready), 64'd1);
    check_output("one_word_busy", 64'(busy), 64'd1);
    check_output("one_word_queue", 64'(exp_q.size()), 64'd0);
    prog = {32'h0020_0113, HALT};
    apply_stimulus(prog, 1, 2, 1'b0);
    wait_done(3);
    toggle_mode = 1'b0;

    $display("[TB] start during LOAD, byte_valid during DONE");
    start_load();
    gen_program(5, prog);
    n = model_len(prog);
    apply_stimulus(prog, 0, n, n > 1);
    wait_done(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_in = 8'($urandom);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    check_output("done_hold_done", 64'(done), 64'd1);
    check_output("done_hold_count", 64'(word_count), 64'(n));
    start_load();
    check_output("restart_core_hold", 64'(core_hold), 64'd1);
    check_output("restart_busy", 64'(busy), 64'd1);
    check_output("restart_mem_add", 64'(bus.mem_add), 64'd0);
    check_output("restart_word_count", 64'(word_count), 64'd0);
    gen_program(3, prog);
    n = model_len(prog);
    apply_stimulus(prog, 0, n, 1'b0);
    wait_done(n);

    $display("[TB] random programs");
    for (int p = 0; p < 6; p++) begin
      start_load();
      gen_program($urandom_range(1, 20), prog);
      n = model_len(prog);
      apply_stimulus(prog, 0, n, 1'b0);
      wait_done(n);
    end

    $display("[TB] reset in the middle of a word");
    start_load();
    gen_program(4, prog);
    prog[0] = 32'h1234_5678;
    prog[1] = 32'h9ABC_DEF0;
    apply_stimulus(prog, 0, 1, 1'b0);
    send_byte(8'hF0);
    send_byte(8'hDE);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midload_reset");
    check_output("midload_queue", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start_load();
    gen_program(4, prog);
    n = model_len(prog);
    apply_stimulus(prog, 0, n, 1'b0);
    wait_done(n);

    $display("[TB] full-depth load without halt");
    start_load();
    prog = {};
    for (int i = 0; i < DEPTH + 4; i++) begin
      logic [31:0] r;
      r = $urandom;
      if (r == HALT) r = 32'h0000_0001;
      prog.push_back(r);
    end
    n = model_len(prog);
    apply_stimulus(prog, 0, n, 1'b0);
    wait_done(DEPTH);
    idle_cycles(3);
    check_output("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in program memory.
REQ-002 Parameter WIDTH, default 32, instruction word width in bits.
REQ-003 Parameter ADD_WIDTH, default 8, program memory address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a load at word address 0.
REQ-007 byte_in  input  8  serial program byte.
REQ-008 byte_valid  input  1  byte_in holds a valid byte.
REQ-009 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-010 mem_we  output  1  program memory write strobe, one cycle per word.
REQ-011 mem_add  output  ADD_WIDTH  program memory write address.
REQ-012 mem_wdata  output  WIDTH  program memory write data.
REQ-013 busy  output  1  load in progress (LOAD or WRITE state).
REQ-014 done  output  1  load complete.
REQ-015 core_hold  output  1  holds the processor core (PC and pipeline) in reset.
REQ-016 word_count  output  ADD_WIDTH+1  number of words written in current/last load.

Function
REQ-017 States SHALL be IDLE, LOAD, WRITE, DONE.
REQ-018 IDLE: start=1 -> LOAD next cycle; mem_add and word_count cleared to 0, byte counter cleared to 0.
REQ-019 LOAD: byte_ready=1; byte accepted only on cycle where byte_valid=1 and byte_ready=1.
REQ-020 Byte order little-endian: accepted byte k (k=0..3) SHALL land in mem_wdata bits [8k+7:8k].
REQ-021 Acceptance of 4th byte -> WRITE next cycle; byte counter wraps to 0.
REQ-022 WRITE: mem_we=1 for exactly one cycle, mem_add = current word address, mem_wdata = assembled word; byte_ready=0.
REQ-023 WRITE: word_count increments by 1 on the cycle leaving WRITE.
REQ-024 WRITE exit: assembled word == 32'h0000007F (halt) or mem_add == DEPTH-1 -> DONE; else mem_add increments by 1 -> LOAD.
REQ-025 mem_add SHALL never wrap past DEPTH-1; 256th word ends the load.
REQ-026 DONE: done=1, core_hold=0, byte_ready=0; state held until start=1 -> LOAD with mem_add, word_count, byte counter cleared.
REQ-027 start ignored in LOAD and WRITE.
REQ-028 byte_valid without byte_ready (IDLE, WRITE, DONE) SHALL be ignored; no byte consumed.
REQ-029 core_hold=1 in IDLE, LOAD, WRITE; 0 only in DONE.
REQ-030 busy=1 exactly in LOAD and WRITE.
REQ-031 mem_we=0 in every state except WRITE; mem_add and mem_wdata stable while mem_we=0.
REQ-032 Latency: mem_we asserts the cycle after the 4th byte handshake; minimum 5 cycles per word.

Reset
REQ-033 rst=1 SHALL immediately force: state IDLE, byte_ready=0, mem_we=0, mem_add=0, mem_wdata=0, busy=0, done=0, core_hold=1, word_count=0, byte counter=0.
REQ-034 rst mid-load SHALL discard partial word with no mem_we; words already written remain in memory.

Verification
REQ-035 start, bytes 93 00 80 00 -> one mem_we, mem_add=0, mem_wdata=32'h00800093, word_count=1, state LOAD.
REQ-036 Load 32'h00800093, 32'h00200113, 32'h0000007F -> mem_we at adds 0,1,2; done=1, core_hold=0, word_count=3.
REQ-037 byte_valid toggled 1/0 every cycle during LOAD -> same words as REQ-035; no byte dropped or duplicated.
REQ-038 256 non-halt words -> last mem_we at mem_add=255, DONE, word_count=256, no write to address 0.
REQ-039 rst asserted after 2 bytes of word 1 -> all outputs at reset values same cycle; restart writes from address 0.
REQ-040 start pulsed during LOAD and byte_valid=1 in DONE -> no effect; second start in DONE restarts at mem_add=0, core_hold=1.
